// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - segmented-carry pipelined adder/subtractor with valid/ready flow control
// Optional build macro: PIPE_ADDSUB_SAT_EN (saturate sum to the signed range on overflow).
// Stage k adds slice k using the carry registered by stage k-1. Upper operand slices
// travel down the pipe until consumed, and finished lower sum slices travel alongside
// them, so every slice of one operation reaches the output register together.

module pipe_addsub #(
    parameter int BW  = 16,
    parameter int SEG = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] a,
    input  logic [BW-1:0] b,
    input  logic          cin,
    input  logic          sub,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] sum,
    output logic          co,
    output logic          neg,
    output logic          ov,
    output logic          zero
);

    localparam int SW = BW / SEG;

    // Subtraction is a + ~b + ~cin, so cin acts as an active-high borrow-in.
    logic [BW-1:0] b_eff_d;
    logic          cin_eff_d;

    assign b_eff_d   = sub ? ~b : b;
    assign cin_eff_d = sub ? ~cin : cin;

    // load_d[k]: stage k captures this cycle; load_d[SEG] is the output consumer.
    logic [SEG:0]   load_d;
    logic [SEG-1:0] vin_d;
    logic [SEG-1:0] en_d;
    logic [SEG-1:0] valid_q;

    // Stage advance chain from the output back to the input, plus per-stage load enables.
    always_comb begin
        load_d      = '0;
        vin_d       = '0;
        load_d[SEG] = out_ready;
        for (int k = SEG - 1; k >= 0; k--) begin
            load_d[k] = ~valid_q[k] | load_d[k+1];
        end
        vin_d[0] = in_valid;
        for (int k = 1; k < SEG; k++) begin
            vin_d[k] = valid_q[k-1];
        end
        en_d = load_d[SEG-1:0] & vin_d;
    end

    // Valid bits: a loading stage takes its upstream valid, a stalled stage keeps its own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= (valid_q & ~load_d[SEG-1:0]) | (vin_d & load_d[SEG-1:0]);
        end
    end

    assign in_ready  = load_d[0];
    assign out_valid = valid_q[SEG-1];

    // Per-slice ripple adders; slice k sees the operands and carry left by stage k-1.
    for (genvar k = 0; k < SEG; k++) begin : g_slice
        logic [SW-1:0] sa;
        logic [SW-1:0] sb;
        logic [SW-1:0] ss;
        logic          ci;
        logic          cs;

        if (k == 0) begin : g_first
            assign sa = a[SW-1:0];
            assign sb = b_eff_d[SW-1:0];
            assign ci = cin_eff_d;
        end else begin : g_next
            assign sa = g_pipe[k-1].a_q[SW-1:0];
            assign sb = g_pipe[k-1].b_q[SW-1:0];
            assign ci = g_pipe[k-1].c_q;
        end

        assign {cs, ss} = {1'b0, sa} + {1'b0, sb} + {{SW{1'b0}}, ci};
    end

    // Intermediate stages: remaining operand slices, finished sum slices and the slice carry.
    for (genvar k = 0; k < SEG - 1; k++) begin : g_pipe
        localparam int OPW  = BW - (k + 1) * SW;
        localparam int SUMW = (k + 1) * SW;

        logic [OPW-1:0]  a_q;
        logic [OPW-1:0]  b_q;
        logic [OPW-1:0]  a_d;
        logic [OPW-1:0]  b_d;
        logic [SUMW-1:0] s_q;
        logic [SUMW-1:0] s_d;
        logic            c_q;

        if (k == 0) begin : g_first
            assign a_d = a[BW-1:SW];
            assign b_d = b_eff_d[BW-1:SW];
            assign s_d = g_slice[0].ss;
        end else begin : g_next
            assign a_d = g_pipe[k-1].a_q[OPW+SW-1:SW];
            assign b_d = g_pipe[k-1].b_q[OPW+SW-1:SW];
            assign s_d = {g_slice[k].ss, g_pipe[k-1].s_q};
        end

        // Capture this stage's slice result and the skewed operands when a valid op moves in.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q <= '0;
                b_q <= '0;
                s_q <= '0;
                c_q <= 1'b0;
            end else if (en_d[k]) begin
                a_q <= a_d;
                b_q <= b_d;
                s_q <= s_d;
                c_q <= g_slice[k].cs;
            end
        end
    end

    // Final stage: assemble the full sum and derive flags from the top slice.
    logic [BW-1:0] raw_d;
    logic [BW-1:0] sum_d;
    logic          co_d;
    logic          msb_cin_d;
    logic          ov_d;

    if (SEG == 1) begin : g_single
        assign raw_d = g_slice[0].ss;
    end else begin : g_multi
        assign raw_d = {g_slice[SEG-1].ss, g_pipe[SEG-2].s_q};
    end

    // The carry into the MSB is recovered from the MSB's own sum bit and operand bits.
    assign co_d      = g_slice[SEG-1].cs;
    assign msb_cin_d = g_slice[SEG-1].sa[SW-1] ^ g_slice[SEG-1].sb[SW-1] ^ g_slice[SEG-1].ss[SW-1];
    assign ov_d      = co_d ^ msb_cin_d;

`ifdef PIPE_ADDSUB_SAT_EN
    // On overflow both operands share a sign; it selects the clamp direction.
    always_comb begin
        sum_d = raw_d;
        if (ov_d) begin
            sum_d = g_slice[SEG-1].sa[SW-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end
    end
`else
    assign sum_d = raw_d;
`endif

    logic [BW-1:0] sum_q;
    logic          co_q;
    logic          neg_q;
    logic          ov_q;
    logic          zero_q;

    // Output register: only written when a valid op enters, so results hold during stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            co_q   <= 1'b0;
            neg_q  <= 1'b0;
            ov_q   <= 1'b0;
            zero_q <= 1'b0;
        end else if (en_d[SEG-1]) begin
            sum_q  <= sum_d;
            co_q   <= co_d;
            neg_q  <= sum_d[BW-1];
            ov_q   <= ov_d;
            zero_q <= (sum_d == '0);
        end
    end

    assign sum  = sum_q;
    assign co   = co_q;
    assign neg  = neg_q;
    assign ov   = ov_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - scoreboard bench for pipe_addsub (BW=16, SEG=4)

module tb_pipe_addsub;

    localparam int BW  = 16;
    localparam int SEG = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] a = '0;
    logic [BW-1:0] b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [BW-1:0] sum;
    logic          co;
    logic          neg;
    logic          ov;
    logic          zero;

    pipe_addsub #(.BW(BW), .SEG(SEG)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co),
        .neg       (neg),
        .ov        (ov),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_in     = 0;
    int n_out    = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act === want) n_pass++;
        else $display("FAIL %s: actual %h expected %h", nm, act, want);
    endtask

    // Reference: unsigned arithmetic for sum/carry, true signed arithmetic for overflow.
    function automatic logic [19:0] model(input logic [15:0] x, input logic [15:0] y,
                                          input logic c, input logic s);
        int ux, uy, sx, sy, ci, full, t;
        logic [15:0] r;
        logic c_o, o;
        ux = x; uy = y; sx = $signed(x); sy = $signed(y); ci = c;
        if (!s) begin
            full = ux + uy + ci;
            t    = sx + sy + ci;
        end else begin
            full = ux + (65535 - uy) + (1 - ci);
            t    = sx - sy - ci;
        end
        r   = full[15:0];
        c_o = full[16];
        o   = (t > 32767) || (t < -32768);
`ifdef PIPE_ADDSUB_SAT_EN
        if (o) r = (t > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {r, c_o, r[15], o, (r == 16'h0000)};
    endfunction

    // Driver side of the scoreboard: every accepted operand set queues its expected result.
    always @(negedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            exp_q.push_back(model(a, b, cin, sub));
            n_in++;
        end
    end

    // Monitor: each output transfer is compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {12'd0, sum, co, neg, ov, zero}, {12'd0, mon_e});
            end
        end
    end

    task automatic send_dir(input logic [15:0] x, input logic [15:0] y, input logic c,
                            input logic s, input logic [19:0] want, input string nm);
        bit got;
        @(posedge clk); #1;
        a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                check(nm, {12'd0, sum, co, neg, ov, zero}, {12'd0, want});
            end
        end
        if (!got) check({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int lat, acc_base, run, out_base, start;

        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_outputs", {12'd0, sum, co, neg, ov, zero}, 32'd0);

        // Single op latency with out_ready held high.
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = 16'h1234; b = 16'h1111; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (out_valid && lat == 0) lat = i;
        end
        check("latency", lat, SEG);

`ifdef PIPE_ADDSUB_SAT_EN
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0}, "pos_overflow");
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b1, 1'b0}, "neg_overflow");
`else
        send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0}, "pos_overflow");
        send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0}, "neg_overflow");
`endif
        send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0}, "sub_negative");
        send_dir(16'h0007, 16'h0007, 1'b0, 1'b1, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}, "sub_zero");
        send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1}, "carry_all_segs");
        send_dir(16'h1234, 16'h1111, 1'b1, 1'b0, {16'h2346, 1'b0, 1'b0, 1'b0, 1'b0}, "add_cin");

        // Fill with the consumer stalled: exactly SEG ops fit.
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_base = n_in;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; a = 16'(i + 1); b = 16'(i * 3); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stall_accepted", n_in - acc_base, SEG);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold", {11'd0, out_valid, sum, co, neg, ov, zero}, {11'd0, 1'b1, exp_q[0]});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        run = 0;
        for (int i = 0; i < SEG; i++) begin
            @(negedge clk);
            if (out_valid) run++;
        end
        check("back_to_back", run, SEG);

        // Reset with three ops in flight, one of them already presented.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = pick_operand(); b = pick_operand();
            cin = 1'($urandom); sub = 1'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_async_in_ready", {31'd0, in_ready}, 32'd1);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        out_base = n_out;
        @(negedge clk);
        check("post_reset_outputs", {11'd0, out_valid, sum, co, neg, ov, zero}, 32'd0);
        send_dir(16'h0100, 16'h0200, 1'b0, 1'b0, {16'h0300, 1'b0, 1'b0, 1'b0, 1'b0}, "first_after_reset");
        repeat (3) @(negedge clk);
        check("no_stale_result", n_out - out_base, 1);

        // Randomized traffic with random throttling on both sides.
        start = n_in;
        for (int c = 0; c < 20000 && (n_in - start) < 1000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a   = pick_operand();
            b   = pick_operand();
            cin = 1'($urandom);
            sub = 1'($urandom);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("random_issued", n_in - start, 1000);
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 SHALL have parameter BW, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SEG, default 4, number of carry-chain segments (= pipeline stages); BW divisible by SEG, 1 <= SEG <= BW.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  operand set presented.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  BW  first operand.
REQ-008 SHALL have port b  input  BW  second operand.
REQ-009 SHALL have port cin  input  1  carry-in (add) / borrow-in (sub).
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid  output  1  result presented.
REQ-012 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-013 SHALL have ports sum (output, BW), co, neg, ov, zero (output, 1 each): result and flags.

Function
REQ-014 Transfer SHALL occur on a rising edge with valid and ready both high (input and output sides independently).
REQ-015 Add SHALL compute a + b + cin; sub SHALL compute a + ~b + ~cin (co = 1 means no borrow).
REQ-016 Stage k (0..SEG-1) SHALL compute bits [(k+1)*BW/SEG-1 : k*BW/SEG] as a ripple chain using the carry registered by stage k-1; stage 0 uses the effective carry-in.
REQ-017 Unconsumed upper operand slices and completed lower sum slices SHALL be skewed in per-stage registers so that all slices of one operation emerge together.
REQ-018 Latency SHALL be SEG cycles from input transfer to out_valid with out_ready held high; throughput one operation per cycle.
REQ-019 Each stage SHALL hold a valid bit; stage k SHALL load when it is empty or stage k+1 loads (k = SEG-1: when out_ready high).
REQ-020 in_ready SHALL equal (stage 0 empty) OR (stage 0 advancing); it depends combinationally on out_ready only through the stage-advance chain.
REQ-021 Capacity SHALL be exactly SEG operations; no operation SHALL be dropped or duplicated under any valid/ready pattern.
REQ-022 While out_valid is high and out_ready low, sum and all flags SHALL remain stable.
REQ-023 co SHALL be carry out of the MSB; ov SHALL be co XOR carry into the MSB; neg SHALL be sum[BW-1]; zero SHALL be 1 iff sum == 0.
REQ-024 SEG = 1 SHALL degenerate to a single registered ripple adder with latency 1.
REQ-025 Simultaneous input and output transfer with a full pipeline SHALL be accepted in the same cycle.

Reset
REQ-026 rst_n low SHALL immediately clear all stage valid bits; out_valid = 0, sum = 0, co = neg = ov = zero = 0, in_ready = 1 after release.
REQ-027 Operations in flight when reset asserts SHALL be discarded; the first transfer after release SHALL produce the first result.

Configuration
REQ-028 Macro PIPE_ADDSUB_SAT_EN SHALL, when defined, clamp sum on ov = 1 to 2^(BW-1)-1 (positive overflow) or -2^(BW-1) (negative overflow), with ov still reported 1 and neg/zero computed on the clamped value.
REQ-029 Without PIPE_ADDSUB_SAT_EN sum SHALL be the wrapped modulo-2^BW result and no saturation logic SHALL exist.

Verification (BW = 16, SEG = 4)
REQ-030 a=0x7FFF, b=0x0001, add, cin=0 -> after 4 cycles sum=0x8000, ov=1, neg=1, co=0, zero=0 (SAT_EN: sum=0x7FFF, neg=0).
REQ-031 a=0x0005, b=0x0007, sub, cin=0 -> sum=0xFFFE, co=0, neg=1, ov=0; a=0x0007, b=0x0007, sub -> sum=0x0000, zero=1, co=1.
REQ-032 a=0xFFFF, b=0x0001, add -> sum=0x0000, co=1, zero=1, ov=0 (carry crosses all 4 segments).
REQ-033 out_ready=0, in_valid=1 for 6 cycles with sequential operands -> exactly 4 accepted, in_ready=0 thereafter; release out_ready -> 4 results in order, back-to-back.
REQ-034 Random valid/ready throttling, 1000 ops vs. reference model -> all results match, in order; rst_n pulsed with 3 ops in flight -> out_valid=0 immediately, no stale result after release.
